link_rx_packer: RTL and testbench
=================================

// Module: link_rx_packer
// PURPOSE
//   Downstream consumer on the req/ack byte link. Acts as the 4-phase handshake
//   receiver: accepts 8-bit bytes from the link master and packs each group of
//   BYTES_PER_WORD bytes (first byte lowest) into one word.
//   Completed words go to a FIFO_DEPTH-word FIFO and leave on a valid/ready port.
//   Back-pressure stalls the link by withholding ack.
// PARAMETERS
//   BYTES_PER_WORD  4  bytes packed per output word (2..8); WORD_W = 8*BYTES_PER_WORD
//   FIFO_DEPTH      4  output FIFO depth in words (power of 2, >=2)
// PORTS
//   clk         in   1        single clock, all state on rising edge
//   rst         in   1        asynchronous, active-low reset (0 = reset asserted)
//   req         in   1        4-phase request from link master
//   data_in     in   8        link byte, stable while req=1
//   ack         out  1        4-phase acknowledge, registered
//   word_out    out  WORD_W   FIFO head word, valid when word_valid=1
//   word_valid  out  1        FIFO not empty
//   word_ready  in   1        consumer accepts word_out this cycle
//   fifo_level  out  log2(FIFO_DEPTH)+1  words currently stored
//   byte_count  out  8        total bytes accepted since reset, wraps 255->0
// BEHAVIOUR
//   Reset (rst=0, async): ack=0, FSM=WAIT_REQ, lane=0, packing reg=0, FIFO empty,
//     word_valid=0, fifo_level=0, byte_count=0. An in-flight byte/partial word is discarded.
//   FSM WAIT_REQ: ack=0. On an edge with req=1 AND can_accept -> capture data_in
//     into lane, lane++, byte_count++, go ACK_HI (ack=1 from next cycle).
//     req=1 with !can_accept -> stay, ack stays 0 (link stalls, no data loss).
//   FSM ACK_HI: ack=1. On an edge with req=0 -> ack=0, go WAIT_REQ. No capture in ACK_HI.
//   Latency: req rise -> ack rise = 1 cycle min; ack fall 1 cycle after req seen low.
//   can_accept = (lane != BYTES_PER_WORD-1) || !fifo_full  (pre-edge full flag;
//     a pop on the same edge does NOT free space for the final byte).
//   Packing: byte k of a word lands in bits [8k+7:8k]. On capture of the last lane,
//     the completed word (incl. this byte) is pushed to the FIFO on the same edge,
//     lane wraps to 0, packing reg cleared.
//   Output: word_out = FIFO head (registered storage, no comb path from data_in).
//     Pop on edge where word_valid && word_ready. word_ready ignored when empty.
//   Simultaneous push+pop (not full, not empty): level unchanged, order preserved.
//   Pointers wrap modulo FIFO_DEPTH; fifo_level distinguishes full from empty.
//   Reset mid-handshake: ack drops immediately; after release a held req=1 is
//     treated as a new byte (master is expected to be reset together).
// TESTING
//   1 Reset: hold rst=0 with req=1 -> ack=0, word_valid=0, byte_count=0, fifo_level=0.
//   2 Send 0x11,0x22,0x33,0x44 via 4-phase, word_ready=1 -> one word 0x44332211,
//     word_valid high exactly 1 cycle after 4th capture edge, byte_count=4.
//   3 word_ready=0, send 16 bytes 0x00..0x0F -> fifo_level=4, words 0x03020100..
//     0x0F0E0D0C; 17th..19th bytes accepted, 20th byte: ack held 0 until one pop,
//     then ack rises next cycle; word order intact.
//   4 Full FIFO, lane=3, assert word_ready and req same cycle -> no capture that
//     edge, capture next edge; fifo_level stays 4.
//   5 Send 3 bytes, pulse rst low while ack=1 -> ack=0 at once; next 4 bytes
//     0xAA,0xBB,0xCC,0xDD yield 0xDDCCBBAA (partial word discarded).
//   6 Send 260 bytes with free-running word_ready -> byte_count=4, 65 words, no stall.

Source files
------------

// File: rtl/link_rx_packer.sv
// Receiver for the 4-phase req/ack byte link: packs bytes (first byte lowest)
// into words, buffers them in a small FIFO and drains it over valid/ready.
module link_rx_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int WORD_W        = 8 * BYTES_PER_WORD,
    localparam int LEVEL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [7:0]         data_in,
    output logic               ack,
    output logic [WORD_W-1:0]  word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic [7:0]         byte_count
);
    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    typedef enum logic {WAIT_REQ, ACK_HI} state_t;

    state_t              state_reg, state_next;
    logic [LANE_W-1:0]   lane_reg;
    logic [7:0]          byte_count_reg;
    logic [WORD_W-1:0]   word_assembled;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LEVEL_W-1:0]  level_reg;
    logic                fifo_full, last_lane, can_accept, capture, push, pop;

    // Full is the pre-edge flag: a pop on the same edge cannot make room for the last byte.
    assign fifo_full  = (level_reg == LEVEL_W'(FIFO_DEPTH));
    assign last_lane  = (lane_reg == LAST_LANE);
    assign can_accept = !last_lane || !fifo_full;
    assign push       = capture && last_lane;
    assign pop        = (level_reg != '0) && word_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= WAIT_REQ;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            WAIT_REQ: begin
                if (req && can_accept) begin
                    capture    = 1'b1;
                    state_next = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req) state_next = WAIT_REQ;
            end
            default: state_next = WAIT_REQ;
        endcase
    end

    // One byte register per lane; the lane being captured is bypassed so the
    // final byte reaches the FIFO on its own capture edge.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        logic [7:0] byte_reg;

        assign word_assembled[8*gi +: 8] = (lane_reg == LANE_W'(gi)) ? data_in : byte_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                                    byte_reg <= '0;
            else if (push)                               byte_reg <= '0;
            else if (capture && lane_reg == LANE_W'(gi)) byte_reg <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_reg       <= '0;
            byte_count_reg <= '0;
        end else if (capture) begin
            lane_reg       <= last_lane ? '0 : lane_reg + LANE_W'(1);
            byte_count_reg <= byte_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= word_assembled;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LEVEL_W'(1);
                2'b01:   level_reg <= level_reg - LEVEL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign ack        = (state_reg == ACK_HI);
    assign word_out   = mem[rd_ptr_reg];
    assign word_valid = (level_reg != '0);
    assign fifo_level = level_reg;
    assign byte_count = byte_count_reg;
endmodule

// File: tb/tb_link_rx_packer.sv
// Directed bench for link_rx_packer: a 4-phase link master drives bytes and
// queues expected words; a monitor compares every word handed out.
module tb_link_rx_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [7:0]  data_in = '0;
    logic        ack;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic [7:0]  byte_count;

    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    logic [31:0] sb [$];

    link_rx_packer #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .fifo_level(fifo_level), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Transfer happens on the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst && word_valid && word_ready) begin
            checks++;
            words_seen++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL word_out: unexpected word %08h, none expected", word_out);
            end else begin
                logic [31:0] exp_w;
                exp_w = sb.pop_front();
                if (word_out !== exp_w) begin
                    errors++;
                    $display("FAIL word_out: got %08h expected %08h", word_out, exp_w);
                end else
                    $display("word ok: %08h", word_out);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, output int cycles);
        cycles = 0;
        while (ack !== val && cycles < 50) begin
            tick();
            cycles++;
        end
        if (ack !== val) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: ack=%b expected %b after %0d cycles", ack, val, cycles);
        end
    endtask

    // Full 4-phase transfer; returns cycles from req rise to ack rise.
    task automatic send_byte(input logic [7:0] b, output int lat);
        int dummy;
        data_in = b;
        req = 1'b1;
        wait_ack(1'b1, lat);
        req = 1'b0;
        wait_ack(1'b0, dummy);
        $display("byte %02h sent, ack latency %0d, byte_count %0d", b, lat, byte_count);
    endtask

    task automatic drain();
        int n;
        n = 0;
        word_ready = 1'b1;
        while (fifo_level != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_level", 64'(fifo_level), 64'd0);
    endtask

    initial begin
        int lat;
        int stalls;
        logic [31:0] w;

        // 1: reset held with req asserted
        rst = 1'b0;
        req = 1'b1;
        data_in = 8'h5A;
        repeat (3) tick();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_word_valid", 64'(word_valid), 64'd0);
        chk("rst_byte_count", 64'(byte_count), 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 2: one word, word_valid right after the 4th capture edge
        word_ready = 1'b1;
        send_byte(8'h11, lat);
        send_byte(8'h22, lat);
        send_byte(8'h33, lat);
        sb.push_back(32'h44332211);
        data_in = 8'h44;
        req = 1'b1;
        tick();
        chk("t2_ack_lat", 64'(ack), 64'd1);
        chk("t2_word_valid", 64'(word_valid), 64'd1);
        req = 1'b0;
        wait_ack(1'b0, lat);
        chk("t2_byte_count", 64'(byte_count), 64'd4);
        drain();

        // 3: fill the FIFO with the consumer stalled
        word_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), lat);
            if (i % 4 == 3) begin
                w = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                sb.push_back(w);
            end
        end
        chk("t3_level_full", 64'(fifo_level), 64'd4);
        for (int i = 16; i < 19; i++) begin
            send_byte(8'(i), lat);
            chk("t3_partial_lat", 64'(lat), 64'd1);
        end
        data_in = 8'h13;
        req = 1'b1;
        repeat (5) tick();
        chk("t3_stall_ack", 64'(ack), 64'd0);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("t3_pop_edge_ack", 64'(ack), 64'd0);
        chk("t3_pop_level", 64'(fifo_level), 64'd3);
        tick();
        chk("t3_ack_after_pop", 64'(ack), 64'd1);
        chk("t3_level_refill", 64'(fifo_level), 64'd4);
        sb.push_back(32'h13121110);
        req = 1'b0;
        wait_ack(1'b0, lat);

        // 4: full FIFO, last lane, pop and req on the same edge
        send_byte(8'h20, lat);
        send_byte(8'h21, lat);
        send_byte(8'h22, lat);
        data_in = 8'h23;
        req = 1'b1;
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("t4_no_capture", 64'(ack), 64'd0);
        tick();
        chk("t4_capture_next", 64'(ack), 64'd1);
        chk("t4_level", 64'(fifo_level), 64'd4);
        sb.push_back(32'h23222120);
        req = 1'b0;
        wait_ack(1'b0, lat);
        drain();
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // 5: reset in the middle of a handshake discards the partial word
        send_byte(8'h50, lat);
        send_byte(8'h51, lat);
        data_in = 8'h52;
        req = 1'b1;
        wait_ack(1'b1, lat);
        rst = 1'b0;
        #1;
        chk("t5_ack_async", 64'(ack), 64'd0);
        chk("t5_byte_count", 64'(byte_count), 64'd0);
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        sb.push_back(32'hDDCCBBAA);
        send_byte(8'hAA, lat);
        send_byte(8'hBB, lat);
        send_byte(8'hCC, lat);
        send_byte(8'hDD, lat);
        drain();
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // 6: long stream, byte counter wraps
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        words_seen = 0;
        stalls = 0;
        word_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            if (i % 4 == 3) begin
                w = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                sb.push_back(w);
            end
            send_byte(8'(i), lat);
            if (lat != 1) stalls++;
        end
        drain();
        chk("t6_stalls", 64'(stalls), 64'd0);
        chk("t6_words", 64'(words_seen), 64'd65);
        chk("t6_byte_count", 64'(byte_count), 64'd4);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
